// File: rtl/fetch2_ibuf.sv
// Second fetch stage: holds one fetch group in S2, waits for the icache and feeds decode from a circular queue.
// Optional same-cycle bypass to decode when the queue is empty: define IBUF_BYPASS_EN.
module fetch2_ibuf #(
   parameter int FETCH_WIDTH = 2,
   parameter int DEPTH       = 8,
   parameter int ECODE_W     = 6,
   localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     f1_valid,
   input  logic [31:0]              f1_pc,
   input  logic                     f1_btb_taken,
   input  logic [SW-1:0]            f1_btb_slot,
   input  logic                     f1_excp_valid,
   input  logic [ECODE_W-1:0]       f1_excp_code,
   output logic                     f1_stall,
   input  logic                     icache_ready,
   input  logic [32*FETCH_WIDTH-1:0] icache_data,
   input  logic                     flush,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [31:0]              dec_inst,
   output logic [31:0]              dec_pc,
   output logic                     dec_btb_taken,
   output logic                     dec_excp_valid,
   output logic [ECODE_W-1:0]       dec_excp_code,
   output logic [CW-1:0]            ibuf_count
);

   logic [DEPTH-1:0][31:0]        inst_q, inst_d, pc_q, pc_d;
   logic [DEPTH-1:0]              btb_q, btb_d, xv_q, xv_d;
   logic [DEPTH-1:0][ECODE_W-1:0] xc_q, xc_d;
   logic [PW-1:0]                 head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]                 count_q, count_d;

   logic                          s2_valid_q, s2_valid_d, s2_btb_q, s2_btb_d, s2_xv_q, s2_xv_d;
   logic [31:0]                   s2_pc_q, s2_pc_d;
   logic [SW-1:0]                 s2_slot_q, s2_slot_d;
   logic [ECODE_W-1:0]            s2_xc_q, s2_xc_d;

   int                            grp_start, grp_last, grp_n, skip;
   logic                          enq_fire, deq, byp, empty;
   logic [31:0]                   base_pc, byp_inst;

   function automatic logic [31:0] slot_inst(input logic [32*FETCH_WIDTH-1:0] d, input int s);
      logic [32*FETCH_WIDTH-1:0] sh;
      sh = d >> (32 * s);
      return sh[31:0];
   endfunction

   // Group geometry; a branch slot before the start slot collapses the group to one entry.
   always_comb begin
      grp_start = int'(s2_pc_q[2 +: SW]) & (FETCH_WIDTH - 1);
      grp_last  = s2_btb_q ? (int'(s2_slot_q) & (FETCH_WIDTH - 1)) : FETCH_WIDTH - 1;
      grp_n     = (s2_xv_q || grp_last < grp_start) ? 1 : grp_last - grp_start + 1;
   end

   assign empty    = (count_q == '0);
   assign enq_fire = s2_valid_q && (icache_ready || s2_xv_q) &&
                     ((DEPTH - int'(count_q)) >= grp_n) && !flush;
   assign deq      = !empty && dec_ready && !flush;
   assign f1_stall = s2_valid_q && !enq_fire && !flush;
   assign base_pc  = s2_pc_q & ~32'(FETCH_WIDTH * 4 - 1);
   assign byp_inst = s2_xv_q ? 32'h0 : slot_inst(icache_data, grp_start);

`ifdef IBUF_BYPASS_EN
   assign byp = empty && enq_fire;
`else
   assign byp = 1'b0;
`endif
   // A bypassed slot accepted by decode is never written to the queue.
   assign skip = (byp && dec_ready) ? 1 : 0;

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_pc_d    = s2_pc_q;
      s2_btb_d   = s2_btb_q;
      s2_slot_d  = s2_slot_q;
      s2_xv_d    = s2_xv_q;
      s2_xc_d    = s2_xc_q;
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (f1_valid && !f1_stall) begin
         s2_valid_d = 1'b1;
         s2_pc_d    = f1_pc;
         s2_btb_d   = f1_btb_taken;
         s2_slot_d  = f1_btb_slot;
         s2_xv_d    = f1_excp_valid;
         s2_xc_d    = f1_excp_code;
      end else if (enq_fire) begin
         s2_valid_d = 1'b0;
      end
   end

   always_comb begin
      inst_d  = inst_q;
      pc_d    = pc_q;
      btb_d   = btb_q;
      xv_d    = xv_q;
      xc_d    = xc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
               if (i < grp_n - skip) begin
                  automatic int            s = grp_start + skip + i;
                  automatic logic [PW-1:0] w = tail_q + PW'(i);
                  inst_d[w] = s2_xv_q ? 32'h0 : slot_inst(icache_data, s);
                  pc_d[w]   = base_pc | 32'(s * 4);
                  btb_d[w]  = s2_btb_q && (s == grp_last);
                  xv_d[w]   = s2_xv_q;
                  xc_d[w]   = s2_xc_q;
               end
            end
            tail_d  = tail_q + PW'(grp_n - skip);
            count_d = count_d + CW'(grp_n - skip);
         end
         if (deq) begin
            head_d  = head_q + PW'(1);
            count_d = count_d - CW'(1);
         end
      end
   end

   always_comb begin
      dec_valid      = !empty || byp;
      dec_inst       = '0;
      dec_pc         = '0;
      dec_btb_taken  = 1'b0;
      dec_excp_valid = 1'b0;
      dec_excp_code  = '0;
      if (byp) begin
         dec_inst       = byp_inst;
         dec_pc         = base_pc | 32'(grp_start * 4);
         dec_btb_taken  = s2_btb_q && (grp_start == grp_last);
         dec_excp_valid = s2_xv_q;
         dec_excp_code  = s2_xc_q;
      end else if (!empty) begin
         dec_inst       = inst_q[head_q];
         dec_pc         = pc_q[head_q];
         dec_btb_taken  = btb_q[head_q];
         dec_excp_valid = xv_q[head_q];
         dec_excp_code  = xc_q[head_q];
      end
   end

   assign ibuf_count = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q     <= '0;
         pc_q       <= '0;
         btb_q      <= '0;
         xv_q       <= '0;
         xc_q       <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_pc_q    <= '0;
         s2_btb_q   <= 1'b0;
         s2_slot_q  <= '0;
         s2_xv_q    <= 1'b0;
         s2_xc_q    <= '0;
      end else begin
         inst_q     <= inst_d;
         pc_q       <= pc_d;
         btb_q      <= btb_d;
         xv_q       <= xv_d;
         xc_q       <= xc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         s2_valid_q <= s2_valid_d;
         s2_pc_q    <= s2_pc_d;
         s2_btb_q   <= s2_btb_d;
         s2_slot_q  <= s2_slot_d;
         s2_xv_q    <= s2_xv_d;
         s2_xc_q    <= s2_xc_d;
      end
   end

endmodule

// File: tb/tb_fetch2_ibuf.sv
// Directed bench for fetch2_ibuf (FETCH_WIDTH=2, DEPTH=8); decode beats are scored against a queue of expected entries.
module tb_fetch2_ibuf;

   logic        clk = 1'b0;
   logic        rst, f1_valid, f1_btb_taken, f1_btb_slot, f1_excp_valid, f1_stall;
   logic [31:0] f1_pc;
   logic [5:0]  f1_excp_code;
   logic        icache_ready, flush, dec_valid, dec_ready, dec_btb_taken, dec_excp_valid;
   logic [63:0] icache_data;
   logic [31:0] dec_inst, dec_pc;
   logic [5:0]  dec_excp_code;
   logic [3:0]  ibuf_count;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        btb;
      logic        xv;
      logic [5:0]  xc;
   } ent_t;

   ent_t sb[$];
   int   errors = 0;
   int   checks = 0;

   fetch2_ibuf #(.FETCH_WIDTH(2), .DEPTH(8), .ECODE_W(6)) dut (
      .clk(clk), .rst(rst),
      .f1_valid(f1_valid), .f1_pc(f1_pc), .f1_btb_taken(f1_btb_taken), .f1_btb_slot(f1_btb_slot),
      .f1_excp_valid(f1_excp_valid), .f1_excp_code(f1_excp_code), .f1_stall(f1_stall),
      .icache_ready(icache_ready), .icache_data(icache_data), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
      .dec_btb_taken(dec_btb_taken), .dec_excp_valid(dec_excp_valid), .dec_excp_code(dec_excp_code),
      .ibuf_count(ibuf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gd(input logic [31:0] pc, input int s);
      return 32'hA5000000 ^ (pc + 32'(s * 4));
   endfunction

   // Expected entries of one group: slots start..last, one entry for exception or illegal groups.
   task automatic push_group(input logic [31:0] pc, input logic btb, input logic bslot,
                             input logic xv, input logic [5:0] xc,
                             input logic [31:0] d0, input logic [31:0] d1);
      int st, ls, n;
      ent_t e;
      st = int'(pc[2]);
      ls = btb ? int'(bslot) : 1;
      n  = (xv || ls < st) ? 1 : ls - st + 1;
      for (int s = st; s < st + n; s++) begin
         e.inst = xv ? 32'h0 : ((s == 0) ? d0 : d1);
         e.pc   = {pc[31:3], s[0], 2'b00};
         e.btb  = btb && (s == ls);
         e.xv   = xv;
         e.xc   = xc;
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && dec_valid && dec_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            ent_t e;
            e = sb.pop_front();
            chk("beat_inst", dec_inst, e.inst);
            chk("beat_pc", dec_pc, e.pc);
            chk("beat_btb", dec_btb_taken, e.btb);
            chk("beat_xv", dec_excp_valid, e.xv);
            chk("beat_xc", dec_excp_code, e.xc);
         end
      end
   end

   initial begin
      logic [31:0] g [5];
      rst = 1'b1; f1_valid = 1'b0; f1_pc = '0; f1_btb_taken = 1'b0; f1_btb_slot = 1'b0;
      f1_excp_valid = 1'b0; f1_excp_code = '0; icache_ready = 1'b0; icache_data = '0;
      flush = 1'b0; dec_ready = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_count", ibuf_count, 0);
      chk("rst_stall", f1_stall, 0);
      chk("rst_inst", dec_inst, 0);
      chk("rst_pc", dec_pc, 0);
      chk("rst_xv", dec_excp_valid, 0);

      // full group, two beats back to back
      tick();
      rst = 1'b0; dec_ready = 1'b1; icache_ready = 1'b1;
      icache_data = {32'h02800842, 32'h02800421};
      f1_valid = 1'b1; f1_pc = 32'h1c000000;
      push_group(32'h1c000000, 1'b0, 1'b0, 1'b0, 6'h0, 32'h02800421, 32'h02800842);
      tick();
      f1_valid = 1'b0;
      @(negedge clk);
      chk("t1_s2_stall", f1_stall, 0);
      chk("t1_s2_count", ibuf_count, 0);
      tick(); @(negedge clk); chk("t1_count_peak", ibuf_count, 2);
      tick(); @(negedge clk); chk("t1_count_second", ibuf_count, 1);
      tick(); @(negedge clk); chk("t1_drained", dec_valid, 0);

      // start slot 1: one entry
      tick();
      f1_valid = 1'b1; f1_pc = 32'h1c000004;
      push_group(32'h1c000004, 1'b0, 1'b0, 1'b0, 6'h0, 32'h02800421, 32'h02800842);
      tick(); f1_valid = 1'b0;
      tick(); @(negedge clk); chk("t2_count", ibuf_count, 1);
      tick(); @(negedge clk); chk("t2_drained", ibuf_count, 0);

      // predicted-taken in slot 0: slot 1 dropped
      tick();
      f1_valid = 1'b1; f1_pc = 32'h1c000000; f1_btb_taken = 1'b1; f1_btb_slot = 1'b0;
      push_group(32'h1c000000, 1'b1, 1'b0, 1'b0, 6'h0, 32'h02800421, 32'h02800842);
      tick(); f1_valid = 1'b0; f1_btb_taken = 1'b0;
      tick(); @(negedge clk); chk("t3_count", ibuf_count, 1);
      tick(); @(negedge clk); chk("t3_drained", ibuf_count, 0);

      // fill to full with decode stalled, fifth group held in S2
      for (int k = 0; k < 5; k++) g[k] = 32'h1c000100 + 32'(k * 8);
      for (int k = 0; k < 5; k++) begin
         tick();
         dec_ready = 1'b0;
         f1_valid = 1'b1; f1_pc = g[k];
         push_group(g[k], 1'b0, 1'b0, 1'b0, 6'h0, gd(g[k], 0), gd(g[k], 1));
         if (k > 0) icache_data = {gd(g[k-1], 1), gd(g[k-1], 0)};
      end
      tick();
      f1_valid = 1'b0; icache_data = {gd(g[4], 1), gd(g[4], 0)};
      @(negedge clk);
      chk("t4_full_count", ibuf_count, 8);
      chk("t4_full_stall", f1_stall, 1);
      tick(); dec_ready = 1'b1;
      @(negedge clk); chk("t4_c8_stall", f1_stall, 1);
      tick();
      @(negedge clk); chk("t4_c7_count", ibuf_count, 7); chk("t4_c7_stall", f1_stall, 1);
      tick(); dec_ready = 1'b0;
      @(negedge clk); chk("t4_c6_count", ibuf_count, 6); chk("t4_c6_stall", f1_stall, 0);
      tick(); @(negedge clk); chk("t4_refill", ibuf_count, 8);
      tick(); dec_ready = 1'b1;
      repeat (8) tick();
      @(negedge clk); chk("t4_drained", ibuf_count, 0);

      // flush with six entries queued and S2 waiting on the icache
      for (int k = 0; k < 4; k++) begin
         tick();
         dec_ready = 1'b0; icache_ready = 1'b1;
         f1_valid = 1'b1; f1_pc = 32'h1c000300 + 32'(k * 8);
         push_group(f1_pc, 1'b0, 1'b0, 1'b0, 6'h0, gd(f1_pc, 0), gd(f1_pc, 1));
         if (k > 0) icache_data = {gd(f1_pc - 32'd8, 1), gd(f1_pc - 32'd8, 0)};
      end
      tick();
      f1_valid = 1'b0; icache_ready = 1'b0;
      @(negedge clk);
      chk("t5_pre_count", ibuf_count, 6);
      chk("t5_pre_stall", f1_stall, 1);
      tick();
      flush = 1'b1; f1_valid = 1'b1; f1_pc = 32'h1c000400;
      sb.delete();
      tick();
      flush = 1'b0; f1_valid = 1'b0; icache_ready = 1'b1; dec_ready = 1'b1;
      @(negedge clk);
      chk("t5_dec_valid", dec_valid, 0);
      chk("t5_count", ibuf_count, 0);
      chk("t5_stall", f1_stall, 0);
      tick(); @(negedge clk);
      chk("t5_stale_count", ibuf_count, 0);
      chk("t5_stale_valid", dec_valid, 0);

      // exception group enqueues without icache_ready
      tick();
      icache_ready = 1'b0;
      f1_valid = 1'b1; f1_pc = 32'h1c000204; f1_excp_valid = 1'b1; f1_excp_code = 6'h08;
      push_group(32'h1c000204, 1'b0, 1'b0, 1'b1, 6'h08, 32'h0, 32'h0);
      tick();
      f1_valid = 1'b0; f1_excp_valid = 1'b0; f1_excp_code = '0;
      @(negedge clk); chk("t6_no_stall", f1_stall, 0);
      tick(); @(negedge clk);
      chk("t6_count", ibuf_count, 1);
      chk("t6_xv", dec_excp_valid, 1);
      chk("t6_xc", dec_excp_code, 6'h08);
      chk("t6_inst", dec_inst, 0);
      tick(); @(negedge clk); chk("t6_drained", ibuf_count, 0);

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch2_ibuf.md
Name: fetch2_ibuf

Overview:
- Second fetch stage, next generation: FETCH_WIDTH-wide icache response plus an instruction queue that decouples fetch from decode.
- Captures one fetch group per cycle from fetch1.
- Waits for the icache, then writes the useful slots into a circular buffer. Slots before the PC offset and slots after a predicted-taken branch are dropped.
- Hands one instruction per cycle to decode over a valid/ready handshake.

Parameters:
- FETCH_WIDTH, 2, instructions per icache response. Legal values: 1, 2, 4.
- DEPTH, 8, queue entries. Power of 2, DEPTH >= FETCH_WIDTH.
- ECODE_W, 6, exception code width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- f1_valid  in  1  fetch1 presents a group.
- f1_pc  in  32  fetch PC, word-aligned. Bits [2 +: log2(FETCH_WIDTH)] give the start slot.
- f1_btb_taken  in  1  predicted-taken branch in this group.
- f1_btb_slot  in  log2(FETCH_WIDTH) (min 1)  slot holding the predicted-taken branch.
- f1_excp_valid  in  1  fetch exception on this group (ADEF/TLB).
- f1_excp_code  in  ECODE_W  exception code.
- f1_stall  out  1  fetch1 must hold its group.
- icache_ready  in  1  icache_data valid this cycle.
- icache_data  in  32*FETCH_WIDTH  slot i = bits [32i +: 32].
- flush  in  1  redirect from the back end.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts the head.
- dec_inst  out  32  instruction.
- dec_pc  out  32  PC of the instruction.
- dec_btb_taken  out  1  instruction is the predicted-taken branch.
- dec_excp_valid  out  1  entry carries an exception.
- dec_excp_code  out  ECODE_W  exception code.
- ibuf_count  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: queue empty, head = tail = 0, s2_valid = 0.
  - Outputs: dec_valid = 0, ibuf_count = 0, f1_stall = 0, all dec_* data = 0.
- S2 register: loads {pc, btb, excp} and sets s2_valid when f1_valid & ~f1_stall & ~flush.
  - When ~f1_valid and the group in S2 enqueues, s2_valid clears.
- Group size:
  - start = pc slot offset; last = f1_btb_taken ? btb_slot : FETCH_WIDTH-1.
  - n = last - start + 1.
  - btb_slot < start is illegal and treated as n = 1.
- Exception group: n = 1. Enqueues without waiting for icache_ready; inst = 32'h0, excp_valid = 1.
- Enqueue fire: s2_valid & (icache_ready | s2_excp) & (DEPTH - ibuf_count >= n) & ~flush.
  - The free-space test uses the count before this cycle's dequeue (conservative).
  - Entries written in slot order at tail .. tail+n-1, modulo DEPTH.
  - Entry pc = {pc[31:2+log2FW], slot, 2'b00}.
  - btb_taken is set only on the entry for slot = last when f1_btb_taken.
- f1_stall = s2_valid & ~enq_fire & ~flush. This is combinational.
- icache_ready while s2_valid = 0 is ignored. This covers stale responses after a flush.
- Dequeue: dec_valid = (ibuf_count != 0). The head pops on dec_valid & dec_ready. dec_* is driven from the head entry register, so the latency is 1 cycle.
- Simultaneous enqueue and dequeue is legal: count += n - 1.
- Pointers wrap modulo DEPTH; full means count == DEPTH.
- Flush takes priority over everything:
  - Next cycle: queue empty, s2_valid = 0, dec_valid = 0.
  - Enqueue and dequeue in the flush cycle are suppressed.
  - f1 inputs in the flush cycle are dropped.
- Reset asserted mid-operation behaves exactly as flush plus the reset values.

Optional Feature:
- Macro IBUF_BYPASS_EN.
- Defined: when the queue is empty and enqueue fires, the first enqueued slot is presented on dec_* in the same cycle (dec_valid = 1, latency 0).
  - If dec_ready, that slot is not written. The remaining n-1 slots are written.
- Undefined: the first instruction appears one cycle after the icache response.

Test Plan:
- FW=2, DEPTH=8. rst, then f1_pc=0x1c000000, no btb, icache_ready same cycle, data {0x02800421, 0x02800842}, dec_ready=1.
  - Required: two dec beats, pc 0x1c000000 then 0x1c000004, in consecutive cycles. ibuf_count peaks at 2.
- f1_pc=0x1c000004 (start slot 1).
  - Required: exactly one entry, pc 0x1c000004, inst = slot 1.
- f1_pc=0x1c000000 with btb_taken, btb_slot=0.
  - Required: one entry with dec_btb_taken = 1; slot 1 dropped.
- dec_ready=0, stream 4 full groups.
  - Required: ibuf_count = 8. The fifth group is held in S2 with f1_stall = 1.
  - Then dec_ready=1 for 2 cycles: the group enqueues on the cycle count reaches 6 and f1_stall drops. Pops are in PC order across the wrap.
- 6 entries queued, S2 waiting on icache; assert flush 1 cycle, then icache_ready=1.
  - Required: dec_valid = 0 and ibuf_count = 0 next cycle; the stale response is not enqueued.
- f1_excp_valid=1, code 0x08, icache_ready=0.
  - Required: one entry, dec_excp_valid = 1, dec_excp_code = 0x08, dec_inst = 0, produced without icache_ready.
